fft_frame_sched: RTL and testbench

- Frame scheduler between the FIR output stream and the shared 16-point FFT engine in the FAS datapath.
- Packs fir_d samples into 16-sample frames using a two-bank ping-pong buffer.
- Starts the FFT engine on each full bank, serves the engine's sample reads, and releases the bank when the engine finishes.
- Counts completed frames, emits fft_valid per frame, and raises done after the last frame.

---
 rtl/fft_frame_sched.sv | 151 +++++++++++++++
 tb/tb_fft_frame_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
// Ping-pong frame scheduler: packs FIR samples into 16-sample banks, hands full
// banks to the shared FFT engine, and tracks completed frames until the run ends.
module fft_frame_sched #(
    parameter int DW     = 16,
    parameter int FRAMES = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fir_valid,
    input  logic [DW-1:0] fir_d,
    output logic          fft_start,
    output logic          fft_bank,
    input  logic [3:0]    fft_rd_addr,
    output logic [DW-1:0] fft_rd_data,
    input  logic          eng_done,
    output logic          fft_valid,
    output logic [6:0]    frame_cnt,
    output logic          overrun,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, BUSY, POST, DONE} state_t;

    state_t        state_q, state_d;
    logic          wr_bank_q, wr_bank_d;
    logic [3:0]    wr_cnt_q, wr_cnt_d;
    logic [1:0]    full_q, full_d;
    logic          rd_bank_q, rd_bank_d;
    logic          fft_start_q, fft_start_d;
    logic          fft_bank_q, fft_bank_d;
    logic          fft_valid_q, fft_valid_d;
    logic [6:0]    frame_cnt_q, frame_cnt_d;
    logic          overrun_q, overrun_d;
    logic          done_q, done_d;

    logic          wr_en;
    logic [DW-1:0] bank_rd [2];

    // The full check uses registered flags, so a bank released this cycle
    // does not accept a sample until the next one.
    assign wr_en = fir_valid && !done_q && !full_q[wr_bank_q];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [DW-1:0] mem [16];

            always_ff @(posedge clk) begin
                if (wr_en && (wr_bank_q == 1'(gi))) begin
                    mem[wr_cnt_q] <= fir_d;
                end
            end

            assign bank_rd[gi] = mem[fft_rd_addr];
        end
    endgenerate

    assign fft_rd_data = bank_rd[fft_bank_q];

    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        full_d      = full_q;
        rd_bank_d   = rd_bank_q;
        fft_start_d = 1'b0;
        fft_bank_d  = fft_bank_q;
        fft_valid_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;
        done_d      = done_q;

        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (wr_cnt_q == 4'd15) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (fir_valid && !done_q && full_q[wr_bank_q]) begin
            overrun_d = 1'b1;
        end

        // Write and release always touch opposite banks, so both updates to full_d compose.
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    fft_start_d = 1'b1;
                    fft_bank_d  = rd_bank_q;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (eng_done) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    frame_cnt_d       = frame_cnt_q + 7'd1;
                    fft_valid_d       = 1'b1;
                    state_d           = POST;
                end
            end
            POST: begin
                if (frame_cnt_q == 7'(FRAMES)) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = DONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= 4'd0;
            full_q      <= 2'b00;
            rd_bank_q   <= 1'b0;
            fft_start_q <= 1'b0;
            fft_bank_q  <= 1'b0;
            fft_valid_q <= 1'b0;
            frame_cnt_q <= 7'd0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            full_q      <= full_d;
            rd_bank_q   <= rd_bank_d;
            fft_start_q <= fft_start_d;
            fft_bank_q  <= fft_bank_d;
            fft_valid_q <= fft_valid_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            done_q      <= done_d;
        end
    end

    assign fft_start = fft_start_q;
    assign fft_bank  = fft_bank_q;
    assign fft_valid = fft_valid_q;
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: directed scenarios plus a randomized run, checked each
// cycle against a frame-level model (sample queue, fill/release edge bookkeeping).
module tb_fft_frame_sched;

    localparam int DW     = 16;
    localparam int FRAMES = 4;

    logic          clk;
    logic          rst;
    logic          fir_valid;
    logic [DW-1:0] fir_d;
    logic          fft_start;
    logic          fft_bank;
    logic [3:0]    fft_rd_addr;
    logic [DW-1:0] fft_rd_data;
    logic          eng_done;
    logic          fft_valid;
    logic [6:0]    frame_cnt;
    logic          overrun;
    logic          done;

    fft_frame_sched #(.DW(DW), .FRAMES(FRAMES)) dut (
        .clk        (clk),
        .rst        (rst),
        .fir_valid  (fir_valid),
        .fir_d      (fir_d),
        .fft_start  (fft_start),
        .fft_bank   (fft_bank),
        .fft_rd_addr(fft_rd_addr),
        .fft_rd_data(fft_rd_data),
        .eng_done   (eng_done),
        .fft_valid  (fft_valid),
        .frame_cnt  (frame_cnt),
        .overrun    (overrun),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame-level model: accepted samples in arrival order, edge numbers of
    // frame fills, starts and releases.
    logic [DW-1:0] acc_q [$];
    int  filled, released, started, edge_n, rel_edge, start_edge, eng_lat;
    int  fill_edge [16];
    bit  dropped, done_exp, eng_busy, eng_hold, force_ed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        fir_valid   = 1'b0;
        fir_d       = '0;
        eng_done    = 1'b0;
        fft_rd_addr = 4'd0;
        @(posedge clk);
        #1;
        acc_q.delete();
        filled = 0; released = 0; started = 0; edge_n = 0; rel_edge = -10; start_edge = 0;
        dropped = 0; done_exp = 0; eng_busy = 0; eng_hold = 0; force_ed = 0;
        check("rst_fft_start", 32'(fft_start), 32'd0);
        check("rst_fft_bank", 32'(fft_bank), 32'd0);
        check("rst_fft_valid", 32'(fft_valid), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        $display("reset applied");
        rst = 1'b1;
    endtask

    // One clock: drive inputs, act as the engine (reads + eng_done), then check outputs.
    task automatic cycle(input logic v, input logic [DW-1:0] d);
        bit auto_ed, blocked, acc, exp_start;
        int addr, es, exp_bank;
        auto_ed = eng_busy && !eng_hold && (edge_n + 1 >= start_edge + eng_lat);
        blocked = done_exp || (filled - released >= 2);
        acc     = v && !blocked;
        if (v && blocked && !done_exp) dropped = 1;
        fir_valid   = v;
        fir_d       = d;
        eng_done    = auto_ed || force_ed;
        addr        = eng_busy ? (edge_n - start_edge) : 0;
        fft_rd_addr = 4'(addr);
        #1;
        if (eng_busy && addr < 16)
            check("rd_data", 32'(fft_rd_data), 32'(acc_q[(started - 1) * 16 + addr]));
        @(posedge clk);
        edge_n++;
        #1;
        if (acc) begin
            acc_q.push_back(d);
            if (acc_q.size() % 16 == 0 && filled < 16) begin
                fill_edge[filled] = edge_n;
                filled++;
            end
        end
        if (auto_ed) begin
            released++;
            rel_edge = edge_n;
            eng_busy = 0;
            $display("frame %0d released at edge %0d", released - 1, edge_n);
        end
        if (released == FRAMES && edge_n == rel_edge + 1) done_exp = 1;
        // A frame starts one edge after it fills, but no earlier than two edges
        // after the previous frame's release (one POST cycle, then IDLE).
        exp_start = 0;
        if (!eng_busy && started < FRAMES && started < filled && started == released) begin
            es = fill_edge[started] + 1;
            if (started > 0 && rel_edge + 2 > es) es = rel_edge + 2;
            exp_start = (edge_n == es);
        end
        check("fft_start", 32'(fft_start), 32'(exp_start));
        if (exp_start) begin
            started++;
            eng_busy   = 1;
            start_edge = edge_n;
            $display("frame %0d start bank %0d at edge %0d", started - 1, (started - 1) % 2, edge_n);
        end
        exp_bank = (started == 0) ? 0 : (started - 1) % 2;
        check("fft_bank", 32'(fft_bank), 32'(exp_bank));
        check("fft_valid", 32'(fft_valid), 32'(auto_ed));
        check("frame_cnt", 32'(frame_cnt), 32'(released));
        check("overrun", 32'(overrun), 32'(dropped));
        check("done", 32'(done), 32'(done_exp));
    endtask

    initial begin
        rst = 1'b0; fir_valid = 1'b0; fir_d = '0; eng_done = 1'b0; fft_rd_addr = 4'd0;

        // Basic frame
        do_reset();
        eng_lat = 8;
        for (int i = 0; i < 16; i++) cycle(1'b1, 16'h0100 + 16'(i));
        cycle(1'b0, '0);
        fft_rd_addr = 4'd5;
        #1;
        check("basic_rd_addr5", 32'(fft_rd_data), 32'h0105);
        for (int k = 0; k < 40 && released < 1; k++) cycle(1'b0, '0);
        check("basic_frame_cnt", 32'(frame_cnt), 32'd1);

        // Ping-pong, engine latency 10
        do_reset();
        eng_lat = 10;
        for (int i = 0; i < 32; i++) cycle(1'b1, 16'($urandom));
        for (int k = 0; k < 100 && released < 2; k++) cycle(1'b0, '0);
        check("pp_frame_cnt", 32'(frame_cnt), 32'd2);
        check("pp_overrun", 32'(overrun), 32'd0);

        // Overrun: engine held while 48 samples arrive
        do_reset();
        eng_lat  = 10;
        eng_hold = 1;
        for (int i = 0; i < 48; i++) cycle(1'b1, 16'($urandom));
        check("ovr_overrun", 32'(overrun), 32'd1);
        check("ovr_frame_cnt", 32'(frame_cnt), 32'd0);
        eng_hold = 0;
        for (int k = 0; k < 20 && released < 1; k++) cycle(1'b0, '0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 16'($urandom));
        for (int k = 0; k < 200 && released < 3; k++) cycle(1'b0, '0);
        check("ovr_frame_cnt_after", 32'(frame_cnt), 32'd3);
        fft_rd_addr = 4'd0;
        #1;
        check("ovr_bank0_addr0", 32'(fft_rd_data), 32'(acc_q[32]));

        // Simultaneous eng_done with 16th write into bank 1, then reset mid-BUSY
        do_reset();
        eng_lat = 15;
        for (int i = 0; i < 32; i++) cycle(1'b1, 16'($urandom));
        for (int k = 0; k < 20 && started < 2; k++) cycle(1'b0, '0);
        check("sim_bank", 32'(fft_bank), 32'd1);
        check("sim_start_edge", 32'(edge_n), 32'd34);
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        do_reset();
        eng_lat = 5;
        for (int i = 0; i < 16; i++) cycle(1'b1, 16'($urandom));
        for (int k = 0; k < 40 && released < 1; k++) cycle(1'b0, '0);
        check("rstmid_frame_cnt", 32'(frame_cnt), 32'd1);

        // Full run, engine latency 20, paced so nothing is dropped
        do_reset();
        eng_lat = 20;
        for (int k = 0; k < 3000 && !done_exp; k++)
            cycle((acc_q.size() < 16 * FRAMES) && (filled - released < 2) && ($urandom_range(0, 3) != 0),
                  16'($urandom));
        check("full_done", 32'(done), 32'd1);
        check("full_frame_cnt", 32'(frame_cnt), 32'(FRAMES));
        force_ed = 1;
        for (int i = 0; i < 10; i++) cycle(1'b1, 16'($urandom));
        force_ed = 0;
        check("full_overrun_after", 32'(overrun), 32'd0);

        // Randomized traffic and engine latency
        do_reset();
        for (int k = 0; k < 4000 && !done_exp; k++) begin
            if (!eng_busy) eng_lat = $urandom_range(1, 24);
            cycle($urandom_range(0, 2) != 0, 16'($urandom));
        end
        check("rand_done", 32'(done), 32'd1);
        for (int i = 0; i < 8; i++) cycle($urandom_range(0, 1) != 0, 16'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
